// File: rtl/dm_arbiter.sv
// Round-robin two-port arbiter/sequencer for the single-port data memory DM.
// Optional read-modify-write for partial-byte stores: define DM_ARB_RMW_EN.
module dm_arbiter #(
  parameter int AW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          p0_req,
  input  logic          p0_we,
  input  logic [3:0]    p0_be,
  input  logic [AW-1:0] p0_addr,
  input  logic [31:0]   p0_wd,
  output logic          p0_ack,
  output logic [31:0]   p0_rd,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [3:0]    p1_be,
  input  logic [AW-1:0] p1_addr,
  input  logic [31:0]   p1_wd,
  output logic          p1_ack,
  output logic [31:0]   p1_rd,
  output logic          dm_we,
  output logic [AW-1:0] dm_addres,
  output logic [31:0]   dm_wd,
  input  logic [31:0]   dm_rd,
  output logic          busy
);

`ifdef DM_ARB_RMW_EN
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_MERGE  = 2'd2,
    S_RESP   = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd3
  } state_t;
`endif

  state_t        r_state;
  logic          r_last_grant;
  logic          r_port;
  logic          r_we;
  logic          r_dm_we;
  logic [AW-1:0] r_dm_addres;
  logic [31:0]   r_dm_wd;
  logic          r_p0_ack;
  logic          r_p1_ack;
  logic [31:0]   r_p0_rd;
  logic [31:0]   r_p1_rd;

  logic          w_grant;
  logic          w_we;
  logic [AW-1:0] w_addr;
  logic [31:0]   w_wd;

  assign w_grant = (p0_req & p1_req) ? ~r_last_grant : p1_req;
  assign w_we    = w_grant ? p1_we   : p0_we;
  assign w_addr  = w_grant ? p1_addr : p0_addr;
  assign w_wd    = w_grant ? p1_wd   : p0_wd;

`ifdef DM_ARB_RMW_EN
  logic [3:0] r_be;
  logic [3:0] w_be;
  logic       w_partial;

  assign w_be      = w_grant ? p1_be : p0_be;
  assign w_partial = (r_be != 4'b1111) && (r_be != 4'b0000);

  function automatic logic [31:0] merge_bytes(input logic [31:0] wd,
                                              input logic [31:0] old,
                                              input logic [3:0]  be);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) begin
      m[8*i +: 8] = be[i] ? wd[8*i +: 8] : old[8*i +: 8];
    end
    return m;
  endfunction
`else
  logic w_unused_be;
  assign w_unused_be = ^{p0_be, p1_be};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_port       <= 1'b0;
      r_we         <= 1'b0;
`ifdef DM_ARB_RMW_EN
      r_be         <= 4'b0000;
`endif
      r_dm_we      <= 1'b0;
      r_dm_addres  <= '0;
      r_dm_wd      <= '0;
      r_p0_ack     <= 1'b0;
      r_p1_ack     <= 1'b0;
      r_p0_rd      <= '0;
      r_p1_rd      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (p0_req | p1_req) begin
            r_port       <= w_grant;
            r_last_grant <= w_grant;
            r_we         <= w_we;
            r_dm_addres  <= w_addr;
            r_dm_wd      <= w_wd;
`ifdef DM_ARB_RMW_EN
            r_be         <= w_be;
            // Only full-word stores write in ACCESS; partial ones write in MERGE.
            r_dm_we      <= w_we & (w_be == 4'b1111);
`else
            r_dm_we      <= w_we;
`endif
            r_state      <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          r_dm_we <= 1'b0;
          if (!r_we) begin
            if (r_port) r_p1_rd <= dm_rd;
            else        r_p0_rd <= dm_rd;
            r_p0_ack <= ~r_port;
            r_p1_ack <= r_port;
            r_state  <= S_RESP;
`ifdef DM_ARB_RMW_EN
          end else if (w_partial) begin
            // r_dm_wd doubles as the merge register: old word merged with new bytes.
            r_dm_wd <= merge_bytes(r_dm_wd, dm_rd, r_be);
            r_dm_we <= 1'b1;
            r_state <= S_MERGE;
`endif
          end else begin
            r_p0_ack <= ~r_port;
            r_p1_ack <= r_port;
            r_state  <= S_RESP;
          end
        end
`ifdef DM_ARB_RMW_EN
        S_MERGE: begin
          r_dm_we  <= 1'b0;
          r_p0_ack <= ~r_port;
          r_p1_ack <= r_port;
          r_state  <= S_RESP;
        end
`endif
        S_RESP: begin
          r_p0_ack <= 1'b0;
          r_p1_ack <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: begin
          r_dm_we  <= 1'b0;
          r_p0_ack <= 1'b0;
          r_p1_ack <= 1'b0;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

  assign dm_we     = r_dm_we;
  assign dm_addres = r_dm_addres;
  assign dm_wd     = r_dm_wd;
  assign p0_ack    = r_p0_ack;
  assign p1_ack    = r_p1_ack;
  assign p0_rd     = r_p0_rd;
  assign p1_rd     = r_p1_rd;
  assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_dm_arbiter.sv
// Scoreboard bench for dm_arbiter with a behavioural single-port DM model.
module tb_dm_arbiter;
  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          p0_req, p0_we, p1_req, p1_we;
  logic [3:0]    p0_be, p1_be;
  logic [AW-1:0] p0_addr, p1_addr;
  logic [31:0]   p0_wd, p1_wd;
  logic          p0_ack, p1_ack;
  logic [31:0]   p0_rd, p1_rd;
  logic          dm_we;
  logic [AW-1:0] dm_addres;
  logic [31:0]   dm_wd;
  logic [31:0]   dm_rd;
  logic          busy;

  always #5 clk = ~clk;

  logic [31:0] mem [0:63];
  always @(posedge clk) if (dm_we) mem[dm_addres[5:0]] <= dm_wd;
  assign dm_rd = mem[dm_addres[5:0]];

  dm_arbiter #(.AW(AW)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_be(p0_be), .p0_addr(p0_addr), .p0_wd(p0_wd),
    .p0_ack(p0_ack), .p0_rd(p0_rd),
    .p1_req(p1_req), .p1_we(p1_we), .p1_be(p1_be), .p1_addr(p1_addr), .p1_wd(p1_wd),
    .p1_ack(p1_ack), .p1_rd(p1_rd),
    .dm_we(dm_we), .dm_addres(dm_addres), .dm_wd(dm_wd), .dm_rd(dm_rd),
    .busy(busy)
  );

  typedef struct {
    int          port;
    bit          is_rd;
    logic [31:0] rd;
  } exp_t;

  exp_t sbq[$];
  exp_t m_e;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   we_cycles = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Monitor: every ack pops the oldest expected completion.
  always @(negedge clk) begin
    if (dm_we) we_cycles++;
    if (!rst && (p0_ack || p1_ack)) begin
      check32("ack_exclusive", {31'b0, p0_ack & p1_ack}, 32'd0);
      if (sbq.size() == 0) begin
        check32("unexpected_ack", {31'b0, p1_ack}, {31'b0, p0_ack});
        check32("unexpected_ack_any", 32'd1, 32'd0);
      end else begin
        m_e = sbq.pop_front();
        check32("ack_port", p1_ack ? 32'd1 : 32'd0, m_e.port);
        if (m_e.is_rd) begin
          if (p1_ack) check32("p1_rd", p1_rd, m_e.rd);
          else        check32("p0_rd", p0_rd, m_e.rd);
        end
      end
    end
  end

  task automatic access(input int port, input bit we, input logic [3:0] be,
                        input logic [AW-1:0] addr, input logic [31:0] wd, output int lat);
    int n;
    bit got;
    if (port == 0) begin
      p0_we = we; p0_be = be; p0_addr = addr; p0_wd = wd; p0_req = 1'b1;
    end else begin
      p1_we = we; p1_be = be; p1_addr = addr; p1_wd = wd; p1_req = 1'b1;
    end
    n = 0;
    got = 1'b0;
    while (!got && n < 20) begin
      @(posedge clk);
      n++;
      #1;
      got = (port == 0) ? p0_ack : p1_ack;
    end
    lat = n;
    check32("ack_seen", {31'b0, got}, 32'd1);
    @(posedge clk);
    #1;
    if (port == 0) p0_req = 1'b0;
    else           p1_req = 1'b0;
  endtask

  task automatic wr(input int port, input logic [3:0] be, input logic [AW-1:0] addr,
                    input logic [31:0] wd, output int lat);
    exp_t e;
    e.port = port; e.is_rd = 1'b0; e.rd = '0;
    sbq.push_back(e);
    access(port, 1'b1, be, addr, wd, lat);
  endtask

  task automatic rd(input int port, input logic [AW-1:0] addr, input logic [31:0] expv);
    exp_t e;
    int   lat;
    e.port = port; e.is_rd = 1'b1; e.rd = expv;
    sbq.push_back(e);
    access(port, 1'b0, 4'b0000, addr, 32'd0, lat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat, lat_full, lat_part, we0;
    logic [31:0] exp15, exp20;
    logic [31:0] p0v [4];
    logic [AW-1:0] p0a [4];
    exp_t        e;

    p0_req = 0; p0_we = 0; p0_be = 0; p0_addr = 0; p0_wd = 0;
    p1_req = 0; p1_we = 0; p1_be = 0; p1_addr = 0; p1_wd = 0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check32("rst_busy",   {31'b0, busy},   32'd0);
    check32("rst_dm_we",  {31'b0, dm_we},  32'd0);
    check32("rst_acks",   {30'b0, p1_ack, p0_ack}, 32'd0);
    check32("rst_addr",   {16'b0, dm_addres}, 32'd0);
    check32("rst_wd",     dm_wd, 32'd0);
    check32("rst_p0_rd",  p0_rd, 32'd0);
    check32("rst_p1_rd",  p1_rd, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    wr(0, 4'b1111, 16'd5,  32'hDEAD0005, lat);
    wr(0, 4'b1111, 16'd15, 32'h11223344, lat);
    wr(0, 4'b1111, 16'd20, 32'h00000021, lat);
    for (int i = 0; i < 4; i++) wr(1, 4'b1111, AW'(30 + i), 32'hA0000030 + i, lat);

    // Reset mid-ACCESS of a full write: the write must never land.
    p0_we = 1'b1; p0_be = 4'b1111; p0_addr = 16'd5; p0_wd = 32'h55555555; p0_req = 1'b1;
    @(posedge clk);
    #1;
    check32("mid_access_we", {31'b0, dm_we}, 32'd1);
    rst = 1'b1;
    #1;
    check32("rst_async_we",   {31'b0, dm_we}, 32'd0);
    check32("rst_async_busy", {31'b0, busy},  32'd0);
    p0_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check32("rst_mem5",      mem[5], 32'hDEAD0005);
    check32("post_rst_busy", {31'b0, busy}, 32'd0);
    check32("post_rst_addr", {16'b0, dm_addres}, 32'd0);
    check32("post_rst_wd",   dm_wd, 32'd0);
    check32("post_rst_p0rd", p0_rd, 32'd0);

    wr(0, 4'b1111, 16'd10, 32'h00000019, lat_full);
    check32("full_wr_latency", lat_full, 32'd2);
    rd(0, 16'd10, 32'h00000019);

`ifdef DM_ARB_RMW_EN
    exp15 = 32'h11BB33DD;
`else
    exp15 = 32'hAABBCCDD;
`endif
    wr(1, 4'b0101, 16'd15, 32'hAABBCCDD, lat_part);
`ifdef DM_ARB_RMW_EN
    check32("partial_wr_latency", lat_part, 32'd3);
`else
    check32("partial_wr_latency", lat_part, 32'd2);
`endif
    rd(1, 16'd15, exp15);

    we0 = we_cycles;
    wr(0, 4'b0000, 16'd20, 32'hFFFFFFFF, lat);
`ifdef DM_ARB_RMW_EN
    exp20 = 32'h00000021;
    check32("be0_no_we", we_cycles - we0, 32'd0);
`else
    exp20 = 32'hFFFFFFFF;
    check32("be0_full_we", we_cycles - we0, 32'd1);
`endif
    check32("be0_mem20", mem[20], exp20);
    rd(0, 16'd20, exp20);

    // Last grant to port 1 so port 0 wins the first tie below.
    rd(1, 16'd30, 32'hA0000030);

    p0a[0] = 16'd10; p0a[1] = 16'd15; p0a[2] = 16'd20; p0a[3] = 16'd5;
    p0v[0] = 32'h00000019; p0v[1] = exp15; p0v[2] = exp20; p0v[3] = 32'hDEAD0005;
    for (int i = 0; i < 4; i++) begin
      e.port = 0; e.is_rd = 1'b1; e.rd = p0v[i]; sbq.push_back(e);
      e.port = 1; e.is_rd = 1'b1; e.rd = 32'hA0000030 + i; sbq.push_back(e);
    end
    fork
      begin
        int l0;
        for (int i = 0; i < 4; i++) access(0, 1'b0, 4'b0000, p0a[i], 32'd0, l0);
      end
      begin
        int l1;
        for (int i = 0; i < 4; i++) access(1, 1'b0, 4'b0000, AW'(30 + i), 32'd0, l1);
      end
    join

    repeat (3) @(posedge clk);
    #1;
    check32("sb_drained", sbq.size(), 32'd0);
    check32("final_busy", {31'b0, busy}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
